hack_rom_loader: RTL and testbench

- Byte-stream programmer for the 1024x16 Hack instruction ROM. It is the writer side of the ROM that the CPU fetches from, and it replaces hierarchical preloading of ROM contents.
- Receives a framed image over a valid/ready byte interface and writes each 16-bit word into ROM.
- Holds the CPU in reset until a frame with a good checksum has been fully received.
- Sits between the external boot/test source and the `rom_inst` write port plus the `cpu_garage` reset.

---
 rtl/hack_rom_loader.sv | 191 +++++++++++++++++++
 tb/tb_hack_rom_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: byte-stream programmer for the 1024x16 Hack instruction ROM.
// Parses frames of the form SYNC, LEN_HI, LEN_LO, LEN x {HI, LO}, CSUM
// (CSUM = XOR of all bytes after SYNC, excluding CSUM itself). Each received
// word is written to ROM one cycle after its LO byte. The CPU is held in reset
// until a whole frame with a good checksum has been received.
//
// Ports:
//   Clk, Reset                 rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  byte stream; transfer when in_valid && in_ready
//   reload                     pulse; restarts the loader from DONE or ERROR
//   rom_we/rom_addr/rom_wdata  ROM write port (one strobe per word)
//   cpu_reset                  1 until a successful load
//   load_done/load_error       frame accepted / last frame rejected
//   words_loaded               words written in the current frame
`timescale 1ns/1ps

module hack_rom_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WORD_W = 16,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reload,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam logic [15:0] MAX_LEN = 16'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_len_hi, w_len_hi_nxt;
  logic [CNT_W-1:0]    r_len, w_len_nxt;
  logic [7:0]          r_hi, w_hi_nxt;
  logic [7:0]          r_xor, w_xor_nxt;
  logic [CNT_W-1:0]    r_words, w_words_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [WORD_W-1:0]   r_wdata, w_wdata_nxt;
  logic                r_err, w_err_nxt;
  logic                r_done;
  logic                r_cpu_reset;

  logic                w_rdy;
  logic                w_acc;
  logic [15:0]         w_len_full;
  logic [CNT_W-1:0]    w_words_inc;

  // Receive states accept bytes; ready is a pure state decode, gated off in reset.
  assign w_rdy = (r_state == S_IDLE)    || (r_state == S_LEN_HI)  ||
                 (r_state == S_LEN_LO)  || (r_state == S_DATA_HI) ||
                 (r_state == S_DATA_LO) || (r_state == S_CSUM);
  assign in_ready    = w_rdy & ~Reset;
  assign w_acc       = in_valid & in_ready;
  assign w_len_full  = {r_len_hi, in_data};
  assign w_words_inc = r_words + CNT_W'(1);

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt  = r_state;
    w_len_hi_nxt = r_len_hi;
    w_len_nxt    = r_len;
    w_hi_nxt     = r_hi;
    w_xor_nxt    = r_xor;
    w_words_nxt  = r_words;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_err_nxt    = r_err;

    case (r_state)
      S_IDLE: begin
        if (w_acc && (in_data == SYNC)) begin
          w_state_nxt = S_LEN_HI;
          w_err_nxt   = 1'b0;
          w_words_nxt = '0;
          w_xor_nxt   = '0;
        end
      end
      S_LEN_HI: begin
        if (w_acc) begin
          w_len_hi_nxt = in_data;
          w_xor_nxt    = r_xor ^ in_data;
          w_state_nxt  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_acc) begin
          w_xor_nxt = r_xor ^ in_data;
          if ((w_len_full == 16'd0) || (w_len_full > MAX_LEN)) begin
            w_state_nxt = S_ERROR;
          end else begin
            w_len_nxt   = CNT_W'(w_len_full);
            w_state_nxt = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_acc) begin
          w_hi_nxt    = in_data;
          w_xor_nxt   = r_xor ^ in_data;
          w_state_nxt = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (w_acc) begin
          w_xor_nxt   = r_xor ^ in_data;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_words[ADDR_W-1:0];
          w_wdata_nxt = WORD_W'({r_hi, in_data});
          w_words_nxt = w_words_inc;
          w_state_nxt = (w_words_inc == r_len) ? S_CSUM : S_DATA_HI;
        end
      end
      S_CSUM: begin
        if (w_acc) begin
          w_state_nxt = (in_data == r_xor) ? S_DONE : S_ERROR;
        end
      end
      S_DONE: begin
        if (reload) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        // Leaves after one cycle whether or not reload is pulsed.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt == S_ERROR) begin
      w_err_nxt = 1'b1;
    end
  end

  // State and datapath registers; status flags follow the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_len_hi    <= '0;
      r_len       <= '0;
      r_hi        <= '0;
      r_xor       <= '0;
      r_words     <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_cpu_reset <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_len_hi    <= w_len_hi_nxt;
      r_len       <= w_len_nxt;
      r_hi        <= w_hi_nxt;
      r_xor       <= w_xor_nxt;
      r_words     <= w_words_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_err       <= w_err_nxt;
      r_done      <= (w_state_nxt == S_DONE);
      r_cpu_reset <= (w_state_nxt != S_DONE);
    end
  end

  assign rom_we       = r_we;
  assign rom_addr     = r_addr;
  assign rom_wdata    = r_wdata;
  assign cpu_reset    = r_cpu_reset;
  assign load_done    = r_done;
  assign load_error   = r_err;
  assign words_loaded = r_words;

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: randomized, self-checking bench for hack_rom_loader.
// A frame-level model parses each byte frame into the list of ROM writes and
// the final status it must produce; a negedge process checks every ROM write
// and the cpu_reset/load_done relation on every cycle.
`timescale 1ns/1ps

module tb_hack_rom_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        rom_we;
  logic [9:0]  rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [10:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [25:0] exp_wr[$];
  logic [15:0] shadow[1024];

  hack_rom_loader #(.ADDR_W(10), .WORD_W(16), .SYNC(SYNC)) dut (
    .Clk(Clk), .Reset(Reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .rom_we(rom_we), .rom_addr(rom_addr),
    .rom_wdata(rom_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 Clk = ~Clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: writes must match the model in order; CPU reset mirrors load status.
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("cpu_reset_vs_done", cpu_reset, !load_done);
      if (rom_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", rom_addr, 32'hFFFF_FFFF);
        end else begin
          logic [25:0] e;
          e = exp_wr.pop_front();
          chk("write_addr", rom_addr, e[25:16]);
          chk("write_data", rom_wdata, e[15:0]);
          chk("words_at_write", words_loaded, 32'(e[25:16]) + 1);
        end
        shadow[rom_addr] = rom_wdata;
      end
    end
  end

  // Frame-level model: skip junk, parse length, queue the writes, judge the checksum.
  task automatic model_frame(input bq_t f, output logic ok, output logic err,
                             output int words, output logic [7:0] x);
    int i = 0;
    int len;
    ok = 1'b0; err = 1'b1; words = 0; x = '0;
    while (i < f.size() && f[i] != SYNC) i++;
    i++;
    len = int'({f[i], f[i+1]});
    x = f[i] ^ f[i+1];
    i += 2;
    if (len == 0 || len > 1024) return;
    for (int w = 0; w < len; w++) begin
      exp_wr.push_back({10'(w), f[i], f[i+1]});
      x ^= f[i] ^ f[i+1];
      i += 2;
    end
    words = len;
    ok = (f[i] == x);
    err = !ok;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge Clk);
    @(negedge Clk);
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) chk("handshake_timeout", 0, 1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic run_frame(input bq_t f, input int gmin, input int gmax, output logic [7:0] x);
    logic ok, err;
    int words;
    model_frame(f, ok, err, words, x);
    foreach (f[k]) send_byte(f[k], gmin + int'($urandom_range(0, gmax - gmin)));
    chk("load_done", load_done, ok);
    chk("load_error", load_error, err);
    chk("cpu_reset", cpu_reset, !ok);
    chk("ready_after_frame", in_ready, 0);
    chk("words_loaded", words_loaded, words);
    chk("pending_writes", exp_wr.size(), 0);
    if (err) begin
      @(posedge Clk); #1;
      chk("ready_back_in_idle", in_ready, 1);
      chk("error_held", load_error, 1);
    end
  endtask

  task automatic do_reload();
    @(negedge Clk); reload = 1'b1;
    @(posedge Clk); #1; reload = 1'b0;
    chk("reload_cpu_reset", cpu_reset, 1);
    chk("reload_done", load_done, 0);
    chk("reload_ready", in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", rom_we, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_wdata", rom_wdata, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_done", load_done, 0);
    chk("rst_error", load_error, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    @(posedge Clk); #1;
    chk("rst_ready_held", in_ready, 0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    bq_t f1, f;
    logic [7:0] x, b;
    int len;
    logic [15:0] wd;

    f1 = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};

    do_reset();

    // Good frame at full rate; literal values pin the model.
    foreach (shadow[k]) shadow[k] = '0;
    run_frame(f1, 0, 0, x);
    chk("model_csum_literal", x, 8'h42);
    chk("rom0_literal", shadow[0], 16'h1234);
    chk("rom1_literal", shadow[1], 16'hABCD);
    chk("words_literal", words_loaded, 2);
    do_reload();

    // Bad checksum, then recovery with a good frame.
    f = f1; f[7] = 8'h43;
    run_frame(f, 0, 0, x);
    chk("bad_rom1_literal", shadow[1], 16'hABCD);
    run_frame(f1, 0, 0, x);
    chk("recover_error_clear", load_error, 0);
    do_reload();

    // Leading junk.
    f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_frame(f, 0, 0, x);
    do_reload();

    // Illegal lengths.
    f = '{8'hA5, 8'h00, 8'h00};
    run_frame(f, 0, 0, x);
    f = '{8'hA5, 8'h04, 8'h01};
    run_frame(f, 0, 0, x);

    // Maximum length frame.
    f = '{8'hA5, 8'h04, 8'h00};
    x = 8'h04;
    for (int w = 0; w < 1024; w++) begin
      wd = 16'(w * 3 + 1);
      f.push_back(wd[15:8]); f.push_back(wd[7:0]);
      x ^= wd[15:8] ^ wd[7:0];
    end
    f.push_back(x);
    run_frame(f, 0, 0, x);
    chk("max_words_literal", words_loaded, 1024);
    chk("max_last_literal", shadow[1023], 16'h0BFE);
    do_reload();

    // Stalls of three cycles between every byte.
    run_frame(f1, 3, 3, x);
    chk("gap_rom0_literal", shadow[0], 16'h1234);
    do_reload();

    // Reset after the first data word abandons the frame.
    f = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h00};
    begin
      logic ok, err; int words;
      model_frame(f, ok, err, words, x);
    end
    for (int k = 0; k < 5; k++) send_byte(f[k], 0);
    @(posedge Clk); #1;
    do_reset();
    chk("abandoned_writes", exp_wr.size(), 2);
    exp_wr.delete();
    shadow[0] = '0;
    run_frame(f1, 0, 0, x);
    chk("after_reset_rom0", shadow[0], 16'h1234);
    do_reload();

    // Randomized frames: junk, random lengths, random gaps, occasional bad checksum.
    for (int r = 0; r < 25; r++) begin
      f = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        f.push_back(b);
      end
      len = int'($urandom_range(1, 16));
      f.push_back(SYNC); f.push_back(8'h00); f.push_back(8'(len));
      x = 8'(len);
      for (int w = 0; w < 2 * len; w++) begin
        b = 8'($urandom);
        f.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 + $urandom_range(0, 254));
      f.push_back(x);
      run_frame(f, 0, 3, x);
      if (load_done) do_reload();
    end

    repeat (3) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
